xbar_scheduler: RTL and testbench

Switch-allocation controller for the router crossbar. Each cycle it arbitrates input-port requests for output ports with one round-robin arbiter per output. It grants at most one input per output and drives the crossbar select and valid lines one cycle later (switch-traversal stage). Under packet locking it holds an output for a wormhole packet from head to tail.

---
 rtl/xbar_scheduler.sv | 146 ++++++++++++++
 tb/tb_xbar_scheduler.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/xbar_scheduler.sv
// xbar_scheduler: per-output round-robin switch allocator, registered xbar select.
// Define XBAR_SCHED_PKT_LOCK_EN to hold an output from head flit to tail flit.
module xbar_scheduler #(
  parameter int INPUT_NUM = 4,
  parameter int OUTPUT_NUM = 4,
  localparam int SEL_SIZE = $clog2(INPUT_NUM),
  localparam int PORT_SIZE = $clog2(OUTPUT_NUM)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [INPUT_NUM-1:0]                 req_i,
  input  logic [INPUT_NUM-1:0][PORT_SIZE-1:0]  out_port_i,
  input  logic [INPUT_NUM-1:0]                 tail_i,
  input  logic [OUTPUT_NUM-1:0]                out_ready_i,
  output logic [INPUT_NUM-1:0]                 grant_o,
  output logic [OUTPUT_NUM-1:0][SEL_SIZE-1:0]  sel_o,
  output logic [OUTPUT_NUM-1:0]                valid_o
);

  logic [OUTPUT_NUM-1:0][INPUT_NUM-1:0] cand;
  logic [OUTPUT_NUM-1:0]                rr_hit;
  logic [OUTPUT_NUM-1:0][SEL_SIZE-1:0]  rr_win;
  logic [OUTPUT_NUM-1:0]                hit;
  logic [OUTPUT_NUM-1:0][SEL_SIZE-1:0]  win;
  logic [OUTPUT_NUM-1:0][SEL_SIZE-1:0]  last_q, last_d;
  logic [OUTPUT_NUM-1:0][SEL_SIZE-1:0]  sel_q, sel_d;
  logic [OUTPUT_NUM-1:0]                valid_q, valid_d;
  logic [SEL_SIZE-1:0]                  idx;

`ifdef XBAR_SCHED_PKT_LOCK_EN
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t                               state_q [OUTPUT_NUM];
  state_t                               state_d [OUTPUT_NUM];
  logic [OUTPUT_NUM-1:0][SEL_SIZE-1:0]  owner_q, owner_d;
`else
  logic                                 unused_tail;
  assign unused_tail = ^tail_i;
`endif

  // Input i competes for output o when it requests that existing port.
  always_comb begin
    cand = '0;
    for (int o = 0; o < OUTPUT_NUM; o++) begin
      for (int i = 0; i < INPUT_NUM; i++) begin
        cand[o][i] = req_i[i]
                  && (32'(out_port_i[i]) == o)
                  && (32'(out_port_i[i]) < OUTPUT_NUM);
      end
    end
  end

  // Round-robin pick per output, scanning from last+1.
  always_comb begin
    rr_hit = '0;
    rr_win = '0;
    idx = '0;
    for (int o = 0; o < OUTPUT_NUM; o++) begin
      for (int k = 1; k <= INPUT_NUM; k++) begin
        idx = SEL_SIZE'((32'(last_q[o]) + 32'(k)) % INPUT_NUM);
        if (!rr_hit[o] && cand[o][idx]) begin
          rr_hit[o] = 1'b1;
          rr_win[o] = idx;
        end
      end
    end
  end

  // Allocation per output plus pointer and lock next state.
  always_comb begin
    hit = '0;
    win = rr_win;
    last_d = last_q;
`ifdef XBAR_SCHED_PKT_LOCK_EN
    state_d = state_q;
    owner_d = owner_q;
`endif
    for (int o = 0; o < OUTPUT_NUM; o++) begin
      if (out_ready_i[o]) begin
`ifdef XBAR_SCHED_PKT_LOCK_EN
        if (state_q[o] == LOCKED) begin
          win[o] = owner_q[o];
          hit[o] = cand[o][owner_q[o]];
          if (hit[o] && tail_i[owner_q[o]]) state_d[o] = IDLE;
        end else if (rr_hit[o]) begin
          hit[o] = 1'b1;
          last_d[o] = rr_win[o];
          if (!tail_i[rr_win[o]]) begin
            state_d[o] = LOCKED;
            owner_d[o] = rr_win[o];
          end
        end
`else
        hit[o] = rr_hit[o];
        if (rr_hit[o]) last_d[o] = rr_win[o];
`endif
      end
    end
    if (!rst) hit = '0;
  end

  // Fold per-output winners into the per-input pop strobe.
  always_comb begin
    grant_o = '0;
    for (int o = 0; o < OUTPUT_NUM; o++) begin
      if (hit[o]) grant_o[win[o]] = 1'b1;
    end
  end

  // Switch-traversal stage: select holds when the output is idle.
  always_comb begin
    valid_d = hit;
    for (int o = 0; o < OUTPUT_NUM; o++) begin
      sel_d[o] = hit[o] ? win[o] : sel_q[o];
    end
  end

  // Pointer and traversal registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q  <= {OUTPUT_NUM{SEL_SIZE'(INPUT_NUM-1)}};
      sel_q   <= '0;
      valid_q <= '0;
    end else begin
      last_q  <= last_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
    end
  end

`ifdef XBAR_SCHED_PKT_LOCK_EN
  // Lock state and owner per output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int o = 0; o < OUTPUT_NUM; o++) state_q[o] <= IDLE;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end
`endif

  assign sel_o   = sel_q;
  assign valid_o = valid_q;

endmodule

// File: tb/tb_xbar_scheduler.sv
// tb_xbar_scheduler: directed vectors, expectations queued to a negedge monitor.
// Lock-dependent expectations follow XBAR_SCHED_PKT_LOCK_EN.
module tb_xbar_scheduler;

  logic            clk;
  logic            rst;
  logic [3:0]      req;
  logic [3:0][1:0] port;
  logic [3:0]      tail;
  logic [3:0]      ready;
  logic [3:0]      grant;
  logic [3:0][1:0] sel;
  logic [3:0]      valid;

  int total = 0;
  int bad = 0;

  typedef struct {
    int         id;
    logic [3:0] g;
    logic [3:0] v;
    logic [3:0] m;
    logic [7:0] s;
  } exp_t;

  exp_t sb[$];
  int   vid = 0;

  xbar_scheduler #(.INPUT_NUM(4), .OUTPUT_NUM(4)) dut (
    .clk(clk),
    .rst(rst),
    .req_i(req),
    .out_port_i(port),
    .tail_i(tail),
    .out_ready_i(ready),
    .grant_o(grant),
    .sel_o(sel),
    .valid_o(valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int id,
                     input logic [7:0] a, input logic [7:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s v%0d got=%h want=%h", nm, id, a, e);
    end
  endtask

  // Apply one cycle of stimulus and queue what the monitor must see.
  task automatic step(input logic r, input logic [3:0] rq,
                      input logic [7:0] pt, input logic [3:0] tl,
                      input logic [3:0] rd, input logic [3:0] eg,
                      input logic [3:0] ev, input logic [3:0] sm,
                      input logic [7:0] es);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r;
    req = rq;
    port = pt;
    tail = tl;
    ready = rd;
    e.id = vid;
    e.g = eg;
    e.v = ev;
    e.m = sm;
    e.s = es;
    sb.push_back(e);
    vid++;
  endtask

  // Monitor: compare grant, valid and masked select fields mid-cycle.
  initial begin
    exp_t e;
    logic [7:0] s8;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        s8 = sel;
        chk("grant", e.id, {4'b0, grant}, {4'b0, e.g});
        chk("valid", e.id, {4'b0, valid}, {4'b0, e.v});
        for (int o = 0; o < 4; o++) begin
          if (e.m[o]) chk($sformatf("sel%0d", o), e.id,
                          {6'b0, s8[2*o +: 2]}, {6'b0, e.s[2*o +: 2]});
        end
      end
    end
  end

  initial begin
    rst = 1'b0;
    req = '0;
    port = '0;
    tail = '0;
    ready = '0;
    // reset: grant masked, outputs cleared
    step(0, 4'b1111, 8'b10101010, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b1111, 8'h00);
    step(0, 4'b1111, 8'b10101010, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b1111, 8'h00);
    step(1, 4'b0000, 8'b10101010, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b1111, 8'h00);
    // four single-flit requesters on port 2 rotate
    step(1, 4'b1111, 8'b10101010, 4'b1111, 4'b1111, 4'b0001, 4'b0000, 4'b0000, 8'h00);
    step(1, 4'b1111, 8'b10101010, 4'b1111, 4'b1111, 4'b0010, 4'b0100, 4'b0100, 8'b00000000);
    step(1, 4'b1111, 8'b10101010, 4'b1111, 4'b1111, 4'b0100, 4'b0100, 4'b0100, 8'b00010000);
    step(1, 4'b1111, 8'b10101010, 4'b1111, 4'b1111, 4'b1000, 4'b0100, 4'b0100, 8'b00100000);
    step(1, 4'b0000, 8'b10101010, 4'b1111, 4'b1111, 4'b0000, 4'b0100, 4'b0100, 8'b00110000);
    step(1, 4'b0000, 8'b10101010, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b0100, 8'b00110000);
    // port 3 backpressured for three cycles
    step(1, 4'b0001, 8'b00000011, 4'b1111, 4'b0111, 4'b0000, 4'b0000, 4'b0000, 8'h00);
    step(1, 4'b0001, 8'b00000011, 4'b1111, 4'b0111, 4'b0000, 4'b0000, 4'b0000, 8'h00);
    step(1, 4'b0001, 8'b00000011, 4'b1111, 4'b0111, 4'b0000, 4'b0000, 4'b0000, 8'h00);
    step(1, 4'b0001, 8'b00000011, 4'b1111, 4'b1111, 4'b0001, 4'b0000, 4'b0000, 8'h00);
    step(1, 4'b0000, 8'b00000011, 4'b1111, 4'b1111, 4'b0000, 4'b1000, 4'b1000, 8'b00000000);
    // conflict-free permutation
    step(1, 4'b1111, 8'b00111001, 4'b1111, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 8'h00);
    step(1, 4'b0000, 8'b00111001, 4'b1111, 4'b1111, 4'b0000, 4'b1111, 4'b1111, 8'b10010011);
    // inputs 0 and 2 contend for port 1
    step(1, 4'b0101, 8'b00010001, 4'b1111, 4'b1111, 4'b0100, 4'b0000, 4'b0000, 8'h00);
    step(1, 4'b0101, 8'b00010001, 4'b1111, 4'b1111, 4'b0001, 4'b0010, 4'b0010, 8'b00001000);
    step(1, 4'b0000, 8'b00010001, 4'b1111, 4'b1111, 4'b0000, 4'b0010, 4'b0010, 8'b00000000);
`ifdef XBAR_SCHED_PKT_LOCK_EN
    // 3-flit packet from input 1 holds port 0 against input 2
    step(1, 4'b0110, 8'h00, 4'b0000, 4'b1111, 4'b0010, 4'b0000, 4'b0000, 8'h00);
    step(1, 4'b0110, 8'h00, 4'b0000, 4'b1111, 4'b0010, 4'b0001, 4'b0001, 8'h01);
    step(1, 4'b0110, 8'h00, 4'b0010, 4'b1111, 4'b0010, 4'b0001, 4'b0001, 8'h01);
    step(1, 4'b0100, 8'h00, 4'b0100, 4'b1111, 4'b0100, 4'b0001, 4'b0001, 8'h01);
    step(1, 4'b0000, 8'h00, 4'b0000, 4'b1111, 4'b0000, 4'b0001, 4'b0001, 8'h02);
    // owner pauses mid-packet, input 3 stays blocked
    step(1, 4'b0010, 8'h00, 4'b0000, 4'b1111, 4'b0010, 4'b0000, 4'b0000, 8'h00);
    step(1, 4'b1000, 8'h00, 4'b0000, 4'b1111, 4'b0000, 4'b0001, 4'b0001, 8'h01);
    step(1, 4'b1000, 8'h00, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 8'h00);
    step(1, 4'b1010, 8'h00, 4'b0010, 4'b1111, 4'b0010, 4'b0000, 4'b0000, 8'h00);
    step(1, 4'b1000, 8'h00, 4'b1000, 4'b1111, 4'b1000, 4'b0001, 4'b0001, 8'h01);
    step(1, 4'b0000, 8'h00, 4'b0000, 4'b1111, 4'b0000, 4'b0001, 4'b0001, 8'h03);
`else
    // same stimulus, every flit arbitrated independently
    step(1, 4'b0110, 8'h00, 4'b0000, 4'b1111, 4'b0010, 4'b0000, 4'b0000, 8'h00);
    step(1, 4'b0110, 8'h00, 4'b0000, 4'b1111, 4'b0100, 4'b0001, 4'b0001, 8'h01);
    step(1, 4'b0110, 8'h00, 4'b0010, 4'b1111, 4'b0010, 4'b0001, 4'b0001, 8'h02);
    step(1, 4'b0100, 8'h00, 4'b0100, 4'b1111, 4'b0100, 4'b0001, 4'b0001, 8'h01);
    step(1, 4'b0000, 8'h00, 4'b0000, 4'b1111, 4'b0000, 4'b0001, 4'b0001, 8'h02);
    step(1, 4'b0010, 8'h00, 4'b0000, 4'b1111, 4'b0010, 4'b0000, 4'b0000, 8'h00);
    step(1, 4'b1000, 8'h00, 4'b0000, 4'b1111, 4'b1000, 4'b0001, 4'b0001, 8'h01);
    step(1, 4'b1000, 8'h00, 4'b0000, 4'b1111, 4'b1000, 4'b0001, 4'b0001, 8'h03);
    step(1, 4'b1010, 8'h00, 4'b0010, 4'b1111, 4'b0010, 4'b0001, 4'b0001, 8'h03);
    step(1, 4'b1000, 8'h00, 4'b1000, 4'b1111, 4'b1000, 4'b0001, 4'b0001, 8'h01);
    step(1, 4'b0000, 8'h00, 4'b0000, 4'b1111, 4'b0000, 4'b0001, 4'b0001, 8'h03);
`endif
    // reset mid-packet, then a new requester wins at once
    step(1, 4'b0010, 8'h00, 4'b0000, 4'b1111, 4'b0010, 4'b0000, 4'b0000, 8'h00);
    step(0, 4'b0010, 8'h00, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b1111, 8'h00);
    step(1, 4'b0000, 8'h00, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b1111, 8'h00);
    step(1, 4'b0100, 8'h00, 4'b0100, 4'b1111, 4'b0100, 4'b0000, 4'b0000, 8'h00);
    step(1, 4'b0000, 8'h00, 4'b0000, 4'b1111, 4'b0000, 4'b0001, 4'b0001, 8'h02);
    for (int n = 0; n < 5 && sb.size() != 0; n++) @(negedge clk);
    @(posedge clk);
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain left=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
